// File: rtl/cpu_pipeline_pkg.sv
// Shared definitions for the UART-fed GCD engine.
// Contents:
//   CLKS_PER_BIT_DEFAULT - default UART bit period in clk cycles
//   state_t              - control FSM encoding (GET_A, GET_B, CALC, SEND)
//   hex_to_seg()         - hex digit to active-low 7-segment pattern, bits g..a
package cpu_pipeline_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 16;

    typedef enum logic [1:0] {
        GET_A,
        GET_B,
        CALC,
        SEND
    } state_t;

    // Active-low segments, index 6..0 = g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/cpu_pipeline_uart_rx.sv
// UART receiver, 8N1, LSB first.
// Ports:
//   clk, reset - system clock, async active-high reset
//   rx         - raw serial line (idle high, asynchronous to clk)
//   data       - last good byte
//   valid      - one-clock pulse when data holds a new byte
module uart_rx
    import cpu_pipeline_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t      state, state_next;
    logic           sync1, sync2, prev;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           bit_end, half_end;

    assign bit_end  = (cnt == CW'(CLKS_PER_BIT - 1));
    assign half_end = (cnt == CW'(CLKS_PER_BIT / 2 - 1));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:  if (prev && !sync2) state_next = RX_START;
            // A start bit that has gone high again by mid-bit was a glitch.
            RX_START: if (half_end) state_next = sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_end && bit_idx == 3'd7) state_next = RX_STOP;
            RX_STOP:  if (bit_end) state_next = RX_IDLE;
            default:  state_next = RX_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: synchronizer flops reset to the idle line level so reset release cannot look like a start edge.
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            prev    <= 1'b1;
            state   <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data    <= '0;
            valid   <= 1'b0;
        end else begin
            sync1 <= rx;
            sync2 <= sync1;
            prev  <= sync2;
            state <= state_next;
            valid <= 1'b0;
            cnt   <= (state_next != state || bit_end) ? '0 : cnt + 1'b1;
            if (state == RX_DATA && bit_end) begin
                shift   <= {sync2, shift[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == RX_STOP && bit_end && sync2) begin
                data  <= shift;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_pipeline_uart_tx.sv
// UART transmitter, 8N1, LSB first.
// Ports:
//   clk, reset - system clock, async active-high reset
//   start      - one-clock request to send data (ignored while sending)
//   data       - byte to send, captured on start
//   tx         - serial line, high whenever idle
//   done       - one-clock pulse after the stop bit completes
module uart_tx
    import cpu_pipeline_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    tx_state_t      state, state_next;
    logic [9:0]     frame;
    logic [CW-1:0]  cnt;
    logic [3:0]     bit_idx;
    logic           bit_end;

    assign bit_end = (cnt == CW'(CLKS_PER_BIT - 1));
    // Frame shifts in ones, so the line drops back to idle on its own.
    assign tx = frame[0];

    always_comb begin
        state_next = state;
        case (state)
            TX_IDLE: if (start) state_next = TX_SEND;
            TX_SEND: if (bit_end && bit_idx == 4'd9) state_next = TX_IDLE;
            default: state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= TX_IDLE;
            frame   <= '1;
            cnt     <= '0;
            bit_idx <= '0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            if (state == TX_IDLE) begin
                cnt     <= '0;
                bit_idx <= '0;
                if (start) frame <= {1'b1, data, 1'b0};
            end else if (bit_end) begin
                cnt     <= '0;
                frame   <= {1'b1, frame[9:1]};
                bit_idx <= bit_idx + 1'b1;
                if (bit_idx == 4'd9) done <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_pipeline.sv
// UART-fed GCD engine: receives operands A then B, computes gcd by
// repeated subtraction, shows the result on led, sends it back over UART,
// and scans the received operands onto a 4-digit 7-segment display.
// Ports:
//   clk, reset - system clock, async active-high reset
//   led        - last GCD result
//   AN         - digit enables, active-low, one low at a time
//   digital    - segments of the enabled digit, active-low, {dp, g..a}
//   UART_TX    - serial result output
//   UART_RX    - serial operand input
module cpu_pipeline
    import cpu_pipeline_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int SCAN_BITS    = 10
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] led,
    output logic [3:0] AN,
    output logic [7:0] digital,
    output logic       UART_TX,
    input  logic       UART_RX
);

    state_t                state, state_next;
    logic [7:0]            a, b, a_rx, b_rx;
    logic [7:0]            rx_data, result;
    logic                  rx_valid, tx_start, tx_done, finish;
    logic [SCAN_BITS-1:0]  scan_cnt;
    logic [3:0]            nib;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk   (clk),
        .reset (reset),
        .rx    (UART_RX),
        .data  (rx_data),
        .valid (rx_valid)
    );

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (tx_start),
        .data  (result),
        .tx    (UART_TX),
        .done  (tx_done)
    );

    // A zero operand short-circuits: gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0.
    assign finish = (a == b) || (a == 8'd0) || (b == 8'd0);
    assign result = (a == 8'd0) ? b : a;

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        case (state)
            GET_A: if (rx_valid) state_next = GET_B;
            GET_B: if (rx_valid) state_next = CALC;
            CALC:  if (finish) begin
                state_next = SEND;
                tx_start   = 1'b1;
            end
            SEND:  if (tx_done) state_next = GET_A;
            default: state_next = GET_A;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= GET_A;
            a     <= '0;
            b     <= '0;
            a_rx  <= '0;
            b_rx  <= '0;
            led   <= '0;
        end else begin
            state <= state_next;
            case (state)
                GET_A: if (rx_valid) begin
                    a    <= rx_data;
                    a_rx <= rx_data;
                end
                GET_B: if (rx_valid) begin
                    b    <= rx_data;
                    b_rx <= rx_data;
                end
                CALC: begin
                    if (finish)     led <= result;
                    else if (a > b) a   <= a - b;
                    else            b   <= b - a;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_cnt <= '0;
            AN       <= 4'b1110;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
            if (&scan_cnt) AN <= {AN[2:0], AN[3]};
        end
    end

    always_comb begin
        nib = 4'h0;
        case (AN)
            4'b1110: nib = b_rx[3:0];
            4'b1101: nib = b_rx[7:4];
            4'b1011: nib = a_rx[3:0];
            4'b0111: nib = a_rx[7:4];
            default: nib = 4'h0;
        endcase
        digital = {1'b1, hex_to_seg(nib)};
    end

endmodule

// File: tb/tb_cpu_pipeline.sv
// Self-checking bench for cpu_pipeline: drives UART operand pairs,
// decodes the returned UART frame, and checks led and the display scan
// against a behavioural model (Euclid gcd and a hex segment table).
module tb_cpu_pipeline;

    localparam int CPB  = 16;
    localparam int SCAN = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       UART_RX = 1'b1;
    logic       UART_TX;
    logic [7:0] led;
    logic [3:0] AN;
    logic [7:0] digital;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_a_rx = 8'h00;
    logic [7:0] exp_b_rx = 8'h00;

    always #5 clk = ~clk;

    cpu_pipeline #(.CLKS_PER_BIT(CPB), .SCAN_BITS(SCAN)) dut (
        .clk     (clk),
        .reset   (reset),
        .led     (led),
        .AN      (AN),
        .digital (digital),
        .UART_TX (UART_TX),
        .UART_RX (UART_RX)
    );

    function automatic logic [7:0] ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x[7:0];
    endfunction

    function automatic logic [7:0] ref_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
            4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
            4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
            4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
        endcase
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] v, input logic stop_bit);
        @(negedge clk);
        UART_RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            UART_RX = v[i];
            repeat (CPB) @(negedge clk);
        end
        UART_RX = stop_bit;
        repeat (CPB) @(negedge clk);
        UART_RX = 1'b1;
    endtask

    // Waits (bounded) for a start bit on UART_TX and decodes one frame.
    task automatic recv_frame(output logic [7:0] v, output bit ok);
        int n = 0;
        v  = 8'h00;
        ok = 1'b0;
        while (UART_TX !== 1'b0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 4000) return;
        repeat (CPB / 2) @(negedge clk);
        if (UART_TX !== 1'b0) return;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            v[i] = UART_TX;
        end
        repeat (CPB) @(negedge clk);
        ok = (UART_TX === 1'b1);
    endtask

    task automatic check_display(input string tag);
        logic [3:0] seen = 4'h0;
        logic [3:0] d;
        for (int i = 0; i < 4 * (1 << SCAN) + 8; i++) begin
            @(negedge clk);
            checks++;
            case (AN)
                4'b1110: begin d = exp_b_rx[3:0]; seen[0] = 1'b1; end
                4'b1101: begin d = exp_b_rx[7:4]; seen[1] = 1'b1; end
                4'b1011: begin d = exp_a_rx[3:0]; seen[2] = 1'b1; end
                4'b0111: begin d = exp_a_rx[7:4]; seen[3] = 1'b1; end
                default: d = 4'hx;
            endcase
            if ($isunknown(d)) begin
                failures++;
                $display("FAIL %s an_onehot: AN=%b required exactly one low bit", tag, AN);
            end else if (digital !== ref_seg(d)) begin
                failures++;
                $display("FAIL %s digit: AN=%b digital=%h required %h", tag, AN, digital, ref_seg(d));
            end
        end
        checks++;
        if (seen !== 4'hF) begin
            failures++;
            $display("FAIL %s scan: digits visited=%b required 1111", tag, seen);
        end
    endtask

    task automatic run_pair(input string tag, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] got;
        logic [7:0] exp;
        bit ok;
        exp = ref_gcd(int'(a), int'(b));
        send_byte(a, 1'b1);
        fork
            send_byte(b, 1'b1);
            recv_frame(got, ok);
        join
        exp_a_rx = a;
        exp_b_rx = b;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s tx_frame: no valid start/stop framing seen, required one frame", tag);
        end
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s tx_byte: got %h required %h (A=%h B=%h)", tag, got, exp, a, b);
        end
        checks++;
        if (led !== exp) begin
            failures++;
            $display("FAIL %s led: got %h required %h (A=%h B=%h)", tag, led, exp, a, b);
        end
        repeat (CPB) @(negedge clk);
        check_display(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (led !== 8'h00 || UART_TX !== 1'b1 || AN !== 4'b1110 || digital !== 8'hC0) begin
            failures++;
            $display("FAIL %s: led=%h tx=%b AN=%b digital=%h required led=00 tx=1 AN=1110 digital=c0",
                     tag, led, UART_TX, AN, digital);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_held");
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_release");
        exp_a_rx = 8'h00;
        exp_b_rx = 8'h00;
        check_display("reset_display");
    endtask

    task automatic test_spec_pairs();
        run_pair("pair_18_24", 8'h18, 8'h24);
        run_pair("pair_30_48", 8'h30, 8'h48);
    endtask

    task automatic test_zero_operands();
        run_pair("zero_a", 8'h00, 8'h07);
        run_pair("zero_both", 8'h00, 8'h00);
        run_pair("zero_b", 8'h2A, 8'h00);
        run_pair("equal", 8'hFF, 8'hFF);
    endtask

    task automatic test_glitch();
        @(negedge clk);
        UART_RX = 1'b0;
        repeat (4) @(negedge clk);
        UART_RX = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_display("glitch_display");
        run_pair("after_glitch", 8'h05, 8'h0A);
    endtask

    task automatic test_framing_error();
        send_byte(8'h55, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        run_pair("after_framing", 8'h09, 8'h06);
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        for (int i = 0; i < 6; i++) begin
            a = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            run_pair("random", a, b);
        end
    endtask

    task automatic test_reset_mid_tx();
        int n = 0;
        send_byte(8'h30, 1'b1);
        fork
            send_byte(8'h48, 1'b1);
            begin
                while (UART_TX !== 1'b0 && n < 4000) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (n >= 4000) begin
                    failures++;
                    $display("FAIL reset_mid_tx wait: no TX frame started within %0d clocks", n);
                end
                repeat (40) @(negedge clk);
                #2 reset = 1'b1;
                #1 check_reset_outputs("reset_mid_tx");
            end
        join
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_a_rx = 8'h00;
        exp_b_rx = 8'h00;
        check_display("reset_mid_tx_display");
        run_pair("after_reset", 8'h18, 8'h24);
    endtask

    initial begin
        test_reset();
        test_spec_pairs();
        test_zero_operands();
        test_glitch();
        test_framing_error();
        test_random();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
